io_bus_master: RTL

CPU-side initiator for the shared tri-state IO bus (data_io / cs_en / wt_en / rd_en) that peripheral register blocks such as the interrupt-enable interface respond on. It accepts one single-word CPU request at a time and decodes the address to a one-hot device select. It runs a fixed-length bus cycle with programmable wait states and returns read data or a write completion to the CPU with a one-cycle ack. It never drives data_io while a peripheral may be driving it.

---
 rtl/io_bus_pkg.sv | 21 ++
 rtl/io_addr_decode.sv | 29 ++
 rtl/io_bus_master.sv | 131 +++++++++++++
 3 files changed

// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared state, address-window and slot constants
// for the CPU-side tri-state IO bus.
package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_e;

  localparam logic [15:0] IO_BASE_HI = 16'hFFFF;
  localparam int unsigned DEV_LSB    = 4;
  localparam int unsigned NUM_DEV    = 8;

  localparam int unsigned DEV_INT_EN = 0;
  localparam int unsigned DEV_TIMER  = 1;
  localparam int unsigned DEV_UART   = 2;
  localparam int unsigned DEV_GPIO   = 3;

endpackage

// File: rtl/io_addr_decode.sv
// io_addr_decode: byte address -> {window hit, one-hot device select}.
// Purely combinational.
module io_addr_decode #(
  parameter int unsigned NUM_DEV = 8,
  parameter int unsigned DEV_LSB = 4,
  parameter logic [15:0] BASE_HI = 16'hFFFF
) (
  input  logic [31:0]        addr_i,
  output logic               hit_o,
  output logic [NUM_DEV-1:0] sel_o
);

  localparam int unsigned DW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

  logic [DW-1:0] dev;
  logic          unused_addr;

  assign dev         = addr_i[DEV_LSB +: DW];
  assign hit_o       = (addr_i[31:16] == BASE_HI) && (32'(dev) < NUM_DEV);
  assign unused_addr = ^addr_i;

  always_comb begin
    sel_o = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      sel_o[i] = hit_o && (dev == DW'(i));
    end
  end

endmodule

// File: rtl/io_bus_master.sv
// io_bus_master: single-outstanding CPU initiator for the shared
// tri-state IO bus with a turnaround SETUP cycle and wait states.
module io_bus_master #(
  parameter int unsigned NUM_DEV     = io_bus_pkg::NUM_DEV,
  parameter int unsigned DEV_LSB     = io_bus_pkg::DEV_LSB,
  parameter logic [15:0] IO_BASE_HI  = io_bus_pkg::IO_BASE_HI,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic               we,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic               ack,
  output logic               err,
  output logic [31:0]        rdata,
  inout  wire  [31:0]        data_io,
  output logic [NUM_DEV-1:0] cs_en,
  output logic               wt_en,
  output logic               rd_en
);

  import io_bus_pkg::state_e;
  import io_bus_pkg::IDLE;
  import io_bus_pkg::SETUP;
  import io_bus_pkg::ACCESS;
  import io_bus_pkg::DONE;

  state_e state_q, state_d;

  logic [3:0]         cnt_q, cnt_d;
  logic               flag_q, flag_d;
  logic               we_q;
  logic [31:0]        addr_q, wdata_q, rdata_q;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [NUM_DEV-1:0] cs_q, cs_d;
  logic               wt_q, wt_d;
  logic               rd_q, rd_d;
  logic               hit;
  logic [NUM_DEV-1:0] sel;

  io_addr_decode #(
    .NUM_DEV (NUM_DEV),
    .DEV_LSB (DEV_LSB),
    .BASE_HI (IO_BASE_HI)
  ) u_dec (
    .addr_i (addr_q),
    .hit_o  (hit),
    .sel_o  (sel)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    unique case (state_q)
      IDLE: begin
        if (req) state_d = SETUP;
      end
      SETUP: begin
        if (hit) begin
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ACCESS;
        end else begin
          flag_d  = 1'b1;
          state_d = DONE;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      DONE: begin
        flag_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Bus strobes follow the next state so they come straight off flops.
    ack_d = (state_d == DONE);
    err_d = (state_d == DONE) && flag_d;
    cs_d  = (state_d == ACCESS) ? sel : '0;
    wt_d  = (state_d == ACCESS) && we_q;
    rd_d  = (state_d == ACCESS) && !we_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= '0;
      wt_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      wt_q    <= wt_d;
      rd_q    <= rd_d;
      if (state_q == IDLE && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (state_q == ACCESS && cnt_q == '0 && !we_q) begin
        rdata_q <= data_io;
      end
    end
  end

  assign data_io = wt_q ? wdata_q : 'z;
  assign ack     = ack_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign cs_en   = cs_q;
  assign wt_en   = wt_q;
  assign rd_en   = rd_q;

endmodule
